// File: rtl/skinny4_inv_sbox_hpc2_pipe_pkg.sv
// Shared types and constants for the masked inverse SKINNY-64 S-box pipeline.
// Build option: SKINNY_INV_SBOX_REFRESH_EN adds an output re-masking stage.
package skinny_masked_pkg;

`ifdef SKINNY_INV_SBOX_REFRESH_EN
  localparam int unsigned LAT     = 10;
  localparam int unsigned FRESH_W = 8;
`else
  localparam int unsigned LAT     = 9;
  localparam int unsigned FRESH_W = 4;
`endif

  localparam int unsigned NUM_LAYERS = 4;

  localparam logic [3:0] INV_S4 [16] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
  };

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
  } share_pair_t;

  // Undoes the forward S-box's left rotation: {a,b,c,d} -> {d,a,b,c}.
  function automatic logic [3:0] rotr1(input logic [3:0] x);
    return {x[0], x[3:1]};
  endfunction

endpackage

// File: rtl/skinny4_inv_sbox_hpc2_pipe_layer.sv
// One NOR-XOR layer of the masked inverse S-box: bit0 ^= NOR(bit3, bit2) via an
// HPC2 AND gadget (2 register stages), then the inverse bit rotation.
module inv_nor_layer_hpc2
  import skinny_masked_pkg::*;
#(
  parameter bit LAST = 1'b0
) (
  input  logic        clk,
  input  share_pair_t x_i,
  input  logic        r_i,
  output share_pair_t y_o
);

  share_pair_t x1_q;
  share_pair_t x2_q;
  logic        r1_q;
  logic        bm0_q;
  logic        bm1_q;
  logic [2:0]  t0_q;
  logic [2:0]  t1_q;
  logic        a0;
  logic        a1;
  logic        b0;
  logic        b1;
  share_pair_t upd;

  // Stage 1: mask the b operand with fresh randomness, delay everything else.
  always_ff @(posedge clk) begin
    x1_q  <= x_i;
    r1_q  <= r_i;
    bm0_q <= ~x_i.s0[2] ^ r_i;
    bm1_q <=  x_i.s1[2] ^ r_i;
  end

  // NOR(a,b) = AND(~a,~b); complementing share 0 complements the shared value.
  assign a0 = ~x1_q.s0[3];
  assign a1 =  x1_q.s1[3];
  assign b0 = ~x1_q.s0[2];
  assign b1 =  x1_q.s1[2];

  // Stage 2: each product term gets its own register so glitches cannot combine them.
  always_ff @(posedge clk) begin
    x2_q <= x1_q;
    t0_q <= {a0 & b0, ~a0 & r1_q, a0 & bm1_q};
    t1_q <= {a1 & b1, ~a1 & r1_q, a1 & bm0_q};
  end

  always_comb begin
    upd       = x2_q;
    upd.s0[0] = x2_q.s0[0] ^ (^t0_q);
    upd.s1[0] = x2_q.s1[0] ^ (^t1_q);
    y_o       = upd;
    if (!LAST) begin
      y_o.s0 = rotr1(upd.s0);
      y_o.s1 = rotr1(upd.s1);
    end
  end

endmodule

// File: rtl/skinny4_inv_sbox_hpc2_pipe.sv
// First-order masked, fully pipelined inverse SKINNY-64 S-box (four HPC2 NOR-XOR layers).
// Build option: SKINNY_INV_SBOX_REFRESH_EN adds a registered output re-masking stage.
module skinny4_inv_sbox_hpc2_pipe
  import skinny_masked_pkg::*;
#(
  parameter int unsigned SECURITY_ORDER = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [3:0]         X_s0,
  input  logic [3:0]         X_s1,
  input  logic [FRESH_W-1:0] Fresh,
  output logic               out_valid,
  output logic [3:0]         Y_s0,
  output logic [3:0]         Y_s1,
  output logic [3:0]         in_flight
);

  if (SECURITY_ORDER != 1) begin : g_order_check
    $error("skinny4_inv_sbox_hpc2_pipe supports SECURITY_ORDER = 1 only");
  end

  share_pair_t        stage_x [NUM_LAYERS+1];
  share_pair_t        y_q;
  logic [LAT-1:0]     vld_q;
  logic [LAT-1:0]     vld_d;
  logic [3:0]         cnt_q;
  logic [3:0]         cnt_d;

  assign stage_x[0] = '{s0: X_s0, s1: X_s1};

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    inv_nor_layer_hpc2 #(
      .LAST(g == NUM_LAYERS - 1)
    ) u_layer (
      .clk (clk),
      .x_i (stage_x[g]),
      .r_i (Fresh[g]),
      .y_o (stage_x[g+1])
    );
  end

`ifdef SKINNY_INV_SBOX_REFRESH_EN
  share_pair_t y_pre_q;

  always_ff @(posedge clk) begin
    y_pre_q <= stage_x[NUM_LAYERS];
  end

  // The same mask on both shares leaves the shared value untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= '{s0: y_pre_q.s0 ^ Fresh[7:4], s1: y_pre_q.s1 ^ Fresh[7:4]};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= stage_x[NUM_LAYERS];
    end
  end
`endif

  always_comb begin
    vld_d = {vld_q[LAT-2:0], in_valid};
    cnt_d = cnt_q + 4'(in_valid) - 4'(vld_q[LAT-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign Y_s0      = y_q.s0;
  assign Y_s1      = y_q.s1;
  assign in_flight = cnt_q;

`ifndef SYNTHESIS
  // Unmasked shadow of the input, only ever observed by the assertions below.
  logic [3:0] shadow_q [LAT];

  always_ff @(posedge clk) begin
    shadow_q[0] <= X_s0 ^ X_s1;
    for (int unsigned k = 1; k < LAT; k++) begin
      shadow_q[k] <= shadow_q[k-1];
    end
  end

  a_function: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> ((Y_s0 ^ Y_s1) == INV_S4[shadow_q[LAT-1]]));

  a_occupancy: assert property (@(posedge clk) disable iff (!rst_n)
    in_flight <= 4'(LAT));
`endif

endmodule
